// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared types and encodings for the forwarding / hazard control block.
package fwd_hazard_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic                 regwrite;
        logic                 memread;
    } shadow_t;

    typedef struct packed {
        shadow_t              ent;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic                 use_rs1;
        logic                 use_rs2;
    } ex_entry_t;

    // x0 is hardwired, so an entry writing it never counts as a producer.
    function automatic logic produces(input shadow_t e, input logic [REG_IDX_W-1:0] r);
        return e.valid && e.regwrite && (e.rd == r) && (r != '0);
    endfunction

    function automatic logic uses_src(input shadow_t e,
                                      input logic [REG_IDX_W-1:0] rs1, input logic use1,
                                      input logic [REG_IDX_W-1:0] rs2, input logic use2);
        return (use1 && produces(e, rs1)) || (use2 && produces(e, rs2));
    endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_sel.sv
// One EX operand bypass select: MEM result beats WB result beats register file.
module fwd_sel
    import fwd_hazard_ctrl_pkg::*;
(
    input  logic                 ex_valid,
    input  logic [REG_IDX_W-1:0] rs,
    input  logic                 use_rs,
    input  shadow_t              mem_ent,
    input  shadow_t              wb_ent,
    output logic [1:0]           sel
);

    always_comb begin
        sel = FWD_RF;
        if (ex_valid && use_rs) begin
            if (produces(mem_ent, rs))
                sel = FWD_MEM;
            else if (produces(wb_ent, rs))
                sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard control for a 5-stage pipeline, tracking EX/MEM/WB in a shadow pipe.
// Define FWD_HAZARD_FORWARD_EN for bypassing + load-use stall; default is interlock-only.
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int XLEN_IDX = REG_IDX_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [XLEN_IDX-1:0] id_rs1,
    input  logic [XLEN_IDX-1:0] id_rs2,
    input  logic [XLEN_IDX-1:0] id_rd,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic                id_regwrite,
    input  logic                id_memread,
    input  logic                ex_flush,
    output logic                stall,
    output logic                flush_ifid,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic [31:0]         stall_count
);

    ex_entry_t ex_q;
    shadow_t   mem_q, wb_q;
    logic      hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_count <= '0;
        end else begin
            mem_q <= ex_q.ent;
            wb_q  <= mem_q;
            if (id_valid && !stall && !ex_flush) begin
                ex_q.ent.valid    <= 1'b1;
                ex_q.ent.rd       <= id_rd;
                ex_q.ent.regwrite <= id_regwrite;
                ex_q.ent.memread  <= id_memread;
                ex_q.rs1          <= id_rs1;
                ex_q.rs2          <= id_rs2;
                ex_q.use_rs1      <= id_use_rs1;
                ex_q.use_rs2      <= id_use_rs2;
            end else begin
                ex_q.ent.valid <= 1'b0;
            end
            if (stall && stall_count != 32'hFFFF_FFFF)
                stall_count <= stall_count + 32'd1;
        end
    end

`ifdef FWD_HAZARD_FORWARD_EN
    // Only a load still in EX cannot be bypassed; everything older comes from MEM/WB.
    assign hazard = id_valid && ex_q.ent.memread &&
                    uses_src(ex_q.ent, id_rs1, id_use_rs1, id_rs2, id_use_rs2);

    fwd_sel u_sel_a (
        .ex_valid (ex_q.ent.valid),
        .rs       (ex_q.rs1),
        .use_rs   (ex_q.use_rs1),
        .mem_ent  (mem_q),
        .wb_ent   (wb_q),
        .sel      (fwd_a)
    );

    fwd_sel u_sel_b (
        .ex_valid (ex_q.ent.valid),
        .rs       (ex_q.rs2),
        .use_rs   (ex_q.use_rs2),
        .mem_ent  (mem_q),
        .wb_ent   (wb_q),
        .sel      (fwd_b)
    );
`else
    // No bypass paths at all, and the register file does not write-through: wait out WB.
    assign hazard = id_valid &&
                    (uses_src(ex_q.ent, id_rs1, id_use_rs1, id_rs2, id_use_rs2) ||
                     uses_src(mem_q,    id_rs1, id_use_rs1, id_rs2, id_use_rs2) ||
                     uses_src(wb_q,     id_rs1, id_use_rs1, id_rs2, id_use_rs2));

    assign fwd_a = FWD_RF;
    assign fwd_b = FWD_RF;
`endif

    assign stall      = hazard && !ex_flush;
    assign flush_ifid = ex_flush;

endmodule
